// File: rtl/data_memory_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : data_memory_arbiter
//  Purpose  : Two-port (pipeline + debug/loader) arbiter onto a single
//             fixed-latency word-addressed data memory. One transaction is
//             in flight at a time: IDLE -> ISSUE -> WAIT (MEM_LATENCY) -> RESP.
//             Misaligned accesses never reach memory; they answer one cycle
//             after acceptance with Ack + Err.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_WIDTH   : data word width
//    ADDR_WIDTH   : byte address width
//    MEM_LATENCY  : memory read latency in cycles (>= 1)
//    STARVE_LIMIT : consecutive pipeline wins before debug is forced
//  Ports
//    clk, rstN                 : clock, async active-low reset
//    pipeReq/We/Addr/Wdata     : pipeline request side
//    pipeAck/Rdata/Err/Stall   : pipeline response side (Stall is comb.)
//    dbgReq/We/Addr/Wdata      : debug/loader request side
//    dbgAck/Rdata/Err          : debug/loader response side
//    memEn/We/Addr/Wdata       : memory command (memAddr is a word address)
//    memRdata                  : memory read data
//    busy                      : transaction in flight
//  Build option
//    DMEM_ARB_STARVE_GUARD_EN  : when defined, debug is granted after
//                                STARVE_LIMIT consecutive pipeline wins
//                                while debug was waiting.
// ============================================================================
module data_memory_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rstN,
  // pipeline port
  input  logic                  pipeReq,
  input  logic                  pipeWe,
  input  logic [ADDR_WIDTH-1:0] pipeAddr,
  input  logic [DATA_WIDTH-1:0] pipeWdata,
  output logic                  pipeAck,
  output logic [DATA_WIDTH-1:0] pipeRdata,
  output logic                  pipeErr,
  output logic                  pipeStall,
  // debug / loader port
  input  logic                  dbgReq,
  input  logic                  dbgWe,
  input  logic [ADDR_WIDTH-1:0] dbgAddr,
  input  logic [DATA_WIDTH-1:0] dbgWdata,
  output logic                  dbgAck,
  output logic [DATA_WIDTH-1:0] dbgRdata,
  output logic                  dbgErr,
  // memory side
  output logic                  memEn,
  output logic                  memWe,
  output logic [ADDR_WIDTH-3:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWdata,
  input  logic [DATA_WIDTH-1:0] memRdata,
  output logic                  busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_WAIT  = 2'd2;
  localparam logic [1:0] c_ST_RESP  = 2'd3;

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] c_WAIT_LAST = CNT_W'(MEM_LATENCY - 1);

  // Elaboration-time sanity check on the configuration.
  if ((MEM_LATENCY < 1) || (STARVE_LIMIT < 1)) begin : g_param_check
    $error("data_memory_arbiter: MEM_LATENCY and STARVE_LIMIT must be >= 1");
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]            state_q,     state_d;
  logic [CNT_W-1:0]      wait_cnt_q,  wait_cnt_d;
  logic                  owner_q,     owner_d;     // 1 = debug owns transaction
  logic                  we_q,        we_d;
  logic                  memEn_q,     memEn_d;
  logic                  memWe_q,     memWe_d;
  logic [ADDR_WIDTH-3:0] memAddr_q,   memAddr_d;
  logic [DATA_WIDTH-1:0] memWdata_q,  memWdata_d;
  logic                  busy_q,      busy_d;
  logic                  pipeAck_q,   pipeAck_d;
  logic                  pipeErr_q,   pipeErr_d;
  logic [DATA_WIDTH-1:0] pipeRdata_q, pipeRdata_d;
  logic                  dbgAck_q,    dbgAck_d;
  logic                  dbgErr_q,    dbgErr_d;
  logic [DATA_WIDTH-1:0] dbgRdata_q,  dbgRdata_d;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic                  w_any_req;
  logic                  w_starve;
  logic                  w_grant_dbg;
  logic                  w_take;
  logic                  w_win_we;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_wdata;
  logic                  w_win_mis;

  assign w_any_req   = pipeReq | dbgReq;
  // Pipeline has priority unless the starvation guard says debug is overdue.
  assign w_grant_dbg = dbgReq & (~pipeReq | w_starve);
  assign w_take      = (state_q == c_ST_IDLE) & w_any_req;
  assign w_win_we    = w_grant_dbg ? dbgWe    : pipeWe;
  assign w_win_addr  = w_grant_dbg ? dbgAddr  : pipeAddr;
  assign w_win_wdata = w_grant_dbg ? dbgWdata : pipeWdata;
  assign w_win_mis   = |w_win_addr[1:0];

`ifdef DMEM_ARB_STARVE_GUARD_EN
  // Counts pipeline grants made while debug was waiting; a debug grant or an
  // idle debug port restarts the count. Saturates at the limit.
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] c_STARVE_LIM = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dbgReq) begin
      starve_cnt_d = '0;
    end else if (w_take) begin
      if (w_grant_dbg) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != c_STARVE_LIM) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign w_starve = (starve_cnt_q == c_STARVE_LIM);
`else
  assign w_starve = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= c_ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      c_ST_IDLE: begin
        // Misaligned winners skip memory and answer on the next cycle.
        if (w_any_req) begin
          state_d = w_win_mis ? c_ST_RESP : c_ST_ISSUE;
        end
      end
      c_ST_ISSUE: begin
        state_d    = c_ST_WAIT;
        wait_cnt_d = '0;
      end
      c_ST_WAIT: begin
        if (wait_cnt_q == c_WAIT_LAST) begin
          state_d = c_ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      c_ST_RESP: begin
        state_d = c_ST_IDLE;
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // --------------------------------------------------------------------------
  logic                  w_resp_enter;
  logic                  w_resp_err;
  logic [DATA_WIDTH-1:0] w_resp_data;

  always_comb begin
    owner_d    = owner_q;
    we_d       = we_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    if (w_take) begin
      owner_d    = w_grant_dbg;
      we_d       = w_win_we;
      memAddr_d  = w_win_addr[ADDR_WIDTH-1:2];
      memWdata_d = w_win_wdata;
    end

    memEn_d = (state_d == c_ST_ISSUE);
    memWe_d = memEn_d & we_d;
    busy_d  = (state_d != c_ST_IDLE);

    // RESP always lasts one cycle, so entering it is exactly the Ack cycle.
    // Entering RESP straight from IDLE only happens for a misaligned access.
    w_resp_enter = (state_d == c_ST_RESP);
    w_resp_err   = (state_q == c_ST_IDLE);
    // memRdata is sampled here on the last WAIT cycle; writes return zero.
    w_resp_data  = (w_resp_err | we_q) ? '0 : memRdata;

    pipeAck_d   = w_resp_enter & ~owner_d;
    dbgAck_d    = w_resp_enter &  owner_d;
    pipeErr_d   = pipeAck_d & w_resp_err;
    dbgErr_d    = dbgAck_d  & w_resp_err;
    pipeRdata_d = pipeAck_d ? w_resp_data : pipeRdata_q;
    dbgRdata_d  = dbgAck_d  ? w_resp_data : dbgRdata_q;
  end

  // --------------------------------------------------------------------------
  // Output and transaction registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      memEn_q     <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      busy_q      <= 1'b0;
      pipeAck_q   <= 1'b0;
      pipeErr_q   <= 1'b0;
      pipeRdata_q <= '0;
      dbgAck_q    <= 1'b0;
      dbgErr_q    <= 1'b0;
      dbgRdata_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      we_q        <= we_d;
      memEn_q     <= memEn_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      busy_q      <= busy_d;
      pipeAck_q   <= pipeAck_d;
      pipeErr_q   <= pipeErr_d;
      pipeRdata_q <= pipeRdata_d;
      dbgAck_q    <= dbgAck_d;
      dbgErr_q    <= dbgErr_d;
      dbgRdata_q  <= dbgRdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output assignments
  // --------------------------------------------------------------------------
  assign memEn     = memEn_q;
  assign memWe     = memWe_q;
  assign memAddr   = memAddr_q;
  assign memWdata  = memWdata_q;
  assign busy      = busy_q;
  assign pipeAck   = pipeAck_q;
  assign pipeErr   = pipeErr_q;
  assign pipeRdata = pipeRdata_q;
  assign dbgAck    = dbgAck_q;
  assign dbgErr    = dbgErr_q;
  assign dbgRdata  = dbgRdata_q;
  // Only combinational output: the pipeline holds while its request is open.
  assign pipeStall = pipeReq & ~pipeAck_q;

endmodule

`default_nettype wire
